uart_tx_serializer: RTL and testbench

- UART transmit stage directly downstream of the baud tick generator. Consumes its one-cycle baud_tick pulse (one pulse per bit period) and serializes parallel bytes onto the tx line.
- Frame format is start bit, data LSB-first, optional parity, then 1 or 2 stop bits.
- A single-entry holding register behind a valid/ready handshake allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_serializer.sv | 131 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// A single-entry holding register lets the next byte queue up behind the frame on the line.
module uart_tx_serializer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);
    localparam logic       OddInit  = 1'(PARITY_ODD);

    state_e               r_state, w_state_d;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic                 r_hold_full, w_hold_full_d;
    logic [3:0]           r_cnt, w_cnt_d;
    logic                 r_parity, w_parity_d;
    logic                 r_tx, w_tx_d;
    logic                 r_busy;
    logic                 w_accept, w_load;

    assign w_accept = tx_valid && !r_hold_full;

    always_comb begin
        w_state_d  = r_state;
        w_shift_d  = r_shift;
        w_cnt_d    = r_cnt;
        w_parity_d = r_parity;
        w_load     = 1'b0;
        if (baud_tick) begin
            unique case (r_state)
                StIdle: begin
                    if (r_hold_full) w_load = 1'b1;
                end
                StStart: begin
                    w_state_d = StData;
                    w_cnt_d   = '0;
                end
                StData: begin
                    w_shift_d = r_shift >> 1;
                    if (r_cnt == LastData) begin
                        w_cnt_d   = '0;
                        w_state_d = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        w_cnt_d = r_cnt + 4'd1;
                    end
                end
                StParity: begin
                    w_state_d = StStop;
                    w_cnt_d   = '0;
                end
                StStop: begin
                    if (r_cnt == LastStop) begin
                        // Chain straight into the next frame when a byte is already waiting.
                        if (r_hold_full) w_load = 1'b1;
                        else             w_state_d = StIdle;
                    end else begin
                        w_cnt_d = r_cnt + 4'd1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
        if (w_load) begin
            w_state_d  = StStart;
            w_shift_d  = r_hold;
            w_parity_d = (^r_hold) ^ OddInit;
            w_cnt_d    = '0;
        end
    end

    // Load and accept are exclusive: one needs the holding register full, the other empty.
    always_comb begin
        w_hold_full_d = r_hold_full;
        if (w_load)        w_hold_full_d = 1'b0;
        else if (w_accept) w_hold_full_d = 1'b1;
    end

    // tx is the registered value of the bit that the next state puts on the line.
    always_comb begin
        w_tx_d = 1'b1;
        unique case (w_state_d)
            StIdle:   w_tx_d = 1'b1;
            StStart:  w_tx_d = 1'b0;
            StData:   w_tx_d = w_shift_d[0];
            StParity: w_tx_d = w_parity_d;
            StStop:   w_tx_d = 1'b1;
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_hold_full <= w_hold_full_d;
            r_shift     <= w_shift_d;
            r_cnt       <= w_cnt_d;
            r_parity    <= w_parity_d;
            r_tx        <= w_tx_d;
            r_busy      <= (r_state != StIdle);
            if (w_accept) r_hold <= tx_data;
        end
    end

    assign tx_ready = !r_hold_full;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (8N1, 8E1, 8O1, 8N2) checked every cycle
// against a frame-queue model, plus hand-computed line samples for the directed cases.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] txo;
    logic [3:0] bsy;
    logic       tick;
    logic [7:0] din [4];
    logic       chk_en;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         tc       = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_serializer #(
            .DATA_BITS (8),
            .PARITY_EN ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD((g == 2) ? 1 : 0),
            .STOP_BITS ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .baud_tick(tick),
            .tx_data  (din[g]),
            .tx_valid (vld[g]),
            .tx_ready (rdy[g]),
            .tx       (txo[g]),
            .busy     (bsy[g])
        );
    end

    // Model: the line is a list of pending bits; a byte waiting in the holding slot becomes
    // a whole new bit list on the tick after the previous list runs dry.
    typedef struct {
        logic        tx;
        logic        busy;
        logic        full;
        logic [7:0]  hold;
        logic [15:0] pend;
        int          n;
        logic        in_frame;
    } model_t;

    model_t m [4];

    function automatic model_t mreset();
        model_t r;
        r.tx = 1'b1; r.busy = 1'b0; r.full = 1'b0; r.hold = '0;
        r.pend = '0; r.n = 0; r.in_frame = 1'b0;
        return r;
    endfunction

    function automatic model_t step(model_t s, int i, logic tk, logic v, logic [7:0] d);
        model_t      r;
        logic [15:0] f;
        int          k;
        r      = s;
        r.busy = s.in_frame;
        if (tk) begin
            if (s.n > 0) begin
                r.tx   = s.pend[0];
                r.pend = s.pend >> 1;
                r.n    = s.n - 1;
            end else if (s.full) begin
                f = 16'(s.hold);
                k = 8;
                if (i == 1 || i == 2) begin
                    f[k] = (($countones(s.hold) % 2) == 1) ^ (i == 2);
                    k++;
                end
                for (int j = 0; j < ((i == 3) ? 2 : 1); j++) begin
                    f[k] = 1'b1;
                    k++;
                end
                r.tx = 1'b0; r.pend = f; r.n = k; r.full = 1'b0; r.in_frame = 1'b1;
            end else begin
                r.tx = 1'b1; r.in_frame = 1'b0;
            end
        end
        if (v && !s.full) begin
            r.full = 1'b1;
            r.hold = d;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            m[i] <= rst[i] ? mreset() : step(m[i], i, tick, vld[i], din[i]);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("tx%0d", i), txo[i], m[i].tx);
                check($sformatf("busy%0d", i), bsy[i], m[i].busy);
                check($sformatf("ready%0d", i), rdy[i], !m[i].full);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            tc++;
            tick = (tc % 4 == 0);
        end
    end

    task automatic send(input int i, input logic [7:0] d);
        int w = 0;
        @(negedge clk);
        while (rdy[i] !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout inst%0d: got no ready expected ready within 300", i);
        end
        vld[i] = 1'b1;
        din[i] = d;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    task automatic wait_start(input int i, output time t);
        int w = 0;
        @(negedge clk);
        while (txo[i] !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_timeout inst%0d: got no start bit expected one within 200", i);
        end
        t = $time;
    endtask

    task automatic wait_until(input time t);
        while ($time < t) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    time         t0;
    int          cnt;
    logic        seen_high;
    logic [10:0] exp55;

    initial begin
        rst    = 4'hF;
        vld    = '0;
        tick   = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", txo[0], 1'b1);
        check("reset_ready", rdy[0], 1'b1);
        check("reset_busy", bsy[0], 1'b0);
        rst = 4'h0;
        repeat (8) @(negedge clk);

        // 8N1 0x55: start, LSB-first data, stop, then idle.
        exp55 = 11'b11010101010;
        send(0, 8'h55);
        wait_start(0, t0);
        for (int j = 0; j <= 10; j++) begin
            wait_until(t0 + 10 * (4 * j + 1));
            check($sformatf("b55_bit%0d", j), txo[0], exp55[j]);
        end
        check("b55_busy_after", bsy[0], 1'b0);
        repeat (10) @(negedge clk);

        // Back-to-back: second byte queued during the first frame's data bits.
        send(0, 8'hA5);
        wait_start(0, t0);
        repeat (8) @(negedge clk);
        send(0, 8'h3C);
        wait_until(t0 + 380);
        check("a5_stop", txo[0], 1'b1);
        wait_until(t0 + 410);
        check("3c_start", txo[0], 1'b0);
        check("3c_busy", bsy[0], 1'b1);
        wait_until(t0 + 880);

        // Parity on 0x07 (three ones): even -> 1, odd -> 0.
        send(1, 8'h07);
        wait_start(1, t0);
        wait_until(t0 + 370);
        check("even_parity", txo[1], 1'b1);
        wait_until(t0 + 410);
        check("even_stop", txo[1], 1'b1);
        send(2, 8'h07);
        wait_start(2, t0);
        wait_until(t0 + 370);
        check("odd_parity", txo[2], 1'b0);
        wait_until(t0 + 410);
        check("odd_stop", txo[2], 1'b1);
        repeat (10) @(negedge clk);

        // Two stop bits: 0xFF gives 8 data + 2 stop = 40 high cycles before 0x00's start.
        send(3, 8'hFF);
        wait_start(3, t0);
        send(3, 8'h00);
        cnt       = 0;
        seen_high = 1'b0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (txo[3] === 1'b1) begin
                seen_high = 1'b1;
                cnt++;
            end else if (seen_high) begin
                break;
            end
        end
        n_checks++;
        if (cnt != 40) begin
            n_fail++;
            $display("FAIL two_stop_high: got %0d cycles expected 40", cnt);
        end
        repeat (60) @(negedge clk);

        // tx_valid held with changing data; only handshake-edge values are sent.
        vld[0] = 1'b1;
        for (int k = 0; k < 150; k++) begin
            din[0] = 8'(8'h10 + k * 7);
            @(negedge clk);
        end
        vld[0] = 1'b0;
        repeat (100) @(negedge clk);

        // Reset during data bit 3 of 0x81 with 0x42 waiting.
        send(0, 8'h81);
        wait_start(0, t0);
        send(0, 8'h42);
        wait_until(t0 + 180);
        check("pre_rst_tx", txo[0], 1'b0);
        check("pre_rst_ready", rdy[0], 1'b0);
        check("pre_rst_busy", bsy[0], 1'b1);
        #2 rst[0] = 1'b1;
        #1;
        check("rst_tx", txo[0], 1'b1);
        check("rst_ready", rdy[0], 1'b1);
        check("rst_busy", bsy[0], 1'b0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        cnt = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (txo[0] !== 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL post_rst_idle: got %0d low cycles expected 0", cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
